// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - key debounce and start/stop/lap/clear FSM driving the stopwatch counter
module stopwatch_ctrl #(
    parameter int DB_TICKS = 2
) (
    input  logic       CLK_50A,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [2:0] key_n,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       lap_load,
    output logic       disp_lap,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_LAP  = 2'b10,
        S_STOP = 2'b11
    } state_t;

    localparam logic [3:0] DB_LIM = 4'(DB_TICKS);

    state_t     cur;
    state_t     nxt;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [1:0] sync_ok;
    logic [2:0] db_level;
    logic [3:0] db_cnt [3];
    logic [2:0] armed;
    logic [2:0] press_d;
    logic [2:0] press;
    logic       ev_start;
    logic       ev_clear;
    logic       ev_lap;
    logic       clr_d;
    logic       lap_d;
    logic       disp_d;
    logic       en_d;

    always_ff @(posedge CLK_50A or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 3'b111;
            sync2   <= 3'b111;
            sync_ok <= 2'b00;
        end else begin
            sync1   <= key_n;
            sync2   <= sync1;
            sync_ok <= {sync_ok[0], 1'b1};
        end
    end

    // A key only generates presses after it has been seen released since reset,
    // so a button held through reset release stays silent.
    always_comb begin
        press_d = '0;
        for (int i = 0; i < 3; i++) begin
            press_d[i] = tick && armed[i] && db_level[i] && !sync2[i]
                         && (db_cnt[i] + 4'd1 == DB_LIM);
        end
    end

    always_ff @(posedge CLK_50A or negedge reset_n) begin
        if (!reset_n) begin
            db_level <= 3'b111;
            armed    <= 3'b000;
            press    <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= 4'd0;
            end
        end else begin
            press <= press_d;
            for (int i = 0; i < 3; i++) begin
                if (sync_ok[1] && sync2[i] && db_level[i]) begin
                    armed[i] <= 1'b1;
                end
                if (tick) begin
                    if (sync2[i] == db_level[i]) begin
                        db_cnt[i] <= 4'd0;
                    end else if (db_cnt[i] + 4'd1 == DB_LIM) begin
                        db_level[i] <= sync2[i];
                        db_cnt[i]   <= 4'd0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 4'd1;
                    end
                end
            end
        end
    end

    assign ev_start = press[0];
    assign ev_clear = press[2] && !press[0];
    assign ev_lap   = press[1] && !press[0] && !press[2];

    always_ff @(posedge CLK_50A or negedge reset_n) begin
        if (!reset_n) begin
            cur      <= S_IDLE;
            cnt_en   <= 1'b0;
            cnt_clr  <= 1'b0;
            lap_load <= 1'b0;
            disp_lap <= 1'b0;
        end else begin
            cur      <= nxt;
            cnt_en   <= en_d;
            cnt_clr  <= clr_d;
            lap_load <= lap_d;
            disp_lap <= disp_d;
        end
    end

    always_comb begin
        nxt    = cur;
        clr_d  = 1'b0;
        lap_d  = 1'b0;
        disp_d = disp_lap;
        en_d   = tick && (cur == S_RUN || cur == S_LAP);
        case (cur)
            S_IDLE: begin
                if (ev_start) begin
                    nxt = S_RUN;
                end else if (ev_clear) begin
                    clr_d = 1'b1;
                end
            end
            S_RUN: begin
                if (ev_start) begin
                    nxt = S_STOP;
                end else if (ev_lap) begin
                    nxt    = S_LAP;
                    lap_d  = 1'b1;
                    disp_d = 1'b1;
                end
            end
            S_LAP: begin
                if (ev_start) begin
                    nxt    = S_STOP;
                    disp_d = 1'b0;
                end else if (ev_clear) begin
                    nxt    = S_RUN;
                    disp_d = 1'b0;
                end else if (ev_lap) begin
                    lap_d = 1'b1;
                end
            end
            S_STOP: begin
                if (ev_start) begin
                    nxt = S_RUN;
                end else if (ev_clear) begin
                    nxt   = S_IDLE;
                    clr_d = 1'b1;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    assign state = cur;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl with a reference model
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic [2:0] key_n;

    logic       cnt_en0, cnt_clr0, lap_load0, disp_lap0;
    logic [1:0] state0;
    logic       cnt_en1, cnt_clr1, lap_load1, disp_lap1;
    logic [1:0] state1;

    stopwatch_ctrl #(.DB_TICKS(2)) dut0 (
        .CLK_50A(clk), .reset_n(reset_n), .tick(tick), .key_n(key_n),
        .cnt_en(cnt_en0), .cnt_clr(cnt_clr0), .lap_load(lap_load0),
        .disp_lap(disp_lap0), .state(state0)
    );

    stopwatch_ctrl #(.DB_TICKS(1)) dut1 (
        .CLK_50A(clk), .reset_n(reset_n), .tick(tick), .key_n(key_n),
        .cnt_en(cnt_en1), .cnt_clr(cnt_clr1), .lap_load(lap_load1),
        .disp_lap(disp_lap1), .state(state1)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model, one slot per instance (0: DB_TICKS=2, 1: DB_TICKS=1).
    // Event codes: 0 none, 1 start, 2 clear, 3 lap. Action bits: 0 clr, 1 lap, 2 disp on, 3 disp off.
    int         nxt_tbl [4][4];
    int         act_tbl [4][4];
    logic [2:0] mk1 [2];
    logic [2:0] mk2 [2];
    logic [2:0] macc [2];
    logic [2:0] marm [2];
    logic [2:0] mprs [2];
    int         mrun [2][3];
    int         mage [2];
    int         mst [2];
    logic       men [2];
    logic       mclr [2];
    logic       mlap [2];
    logic       mdisp [2];

    int obs_en, obs_clr, obs_lap, obs_lap1;

    typedef struct {
        logic [2:0] key;
        int         nt;
        logic [1:0] st;
        int         en;
        int         clr;
        int         lap;
        logic       disp;
    } seg_t;

    seg_t segs [29];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic t, input logic [2:0] k);
        for (int m = 0; m < 2; m++) begin
            int         dbv;
            int         ev;
            int         act;
            logic [2:0] syn;
            logic [2:0] newp;
            dbv = (m == 0) ? 2 : 1;
            if (!r) begin
                mk1[m] = 3'b111; mk2[m] = 3'b111; macc[m] = 3'b111;
                marm[m] = 3'b000; mprs[m] = 3'b000; mage[m] = 0; mst[m] = 0;
                men[m] = 0; mclr[m] = 0; mlap[m] = 0; mdisp[m] = 0;
                for (int i = 0; i < 3; i++) mrun[m][i] = 0;
            end else begin
                syn = mk2[m];
                ev = mprs[m][0] ? 1 : mprs[m][2] ? 2 : mprs[m][1] ? 3 : 0;
                men[m] = t && (mst[m] == 1 || mst[m] == 2);
                act = act_tbl[mst[m]][ev];
                mclr[m] = act[0];
                mlap[m] = act[1];
                if (act[2]) mdisp[m] = 1'b1;
                if (act[3]) mdisp[m] = 1'b0;
                mst[m] = nxt_tbl[mst[m]][ev];
                newp = 3'b000;
                for (int i = 0; i < 3; i++) begin
                    logic arm_now;
                    newp[i] = t && marm[m][i] && macc[m][i] && !syn[i] && (mrun[m][i] + 1 == dbv);
                    arm_now = (mage[m] >= 2) && syn[i] && macc[m][i];
                    if (t) begin
                        if (syn[i] == macc[m][i]) mrun[m][i] = 0;
                        else if (mrun[m][i] + 1 == dbv) begin
                            macc[m][i] = syn[i];
                            mrun[m][i] = 0;
                        end else mrun[m][i] = mrun[m][i] + 1;
                    end
                    if (arm_now) marm[m][i] = 1'b1;
                end
                mprs[m] = newp;
                mk2[m] = mk1[m];
                mk1[m] = k;
                if (mage[m] < 2) mage[m] = mage[m] + 1;
            end
        end
    endtask

    task automatic cmp_model(input int m, input logic [5:0] got);
        logic [5:0] want;
        want = {2'(mst[m]), mdisp[m], mlap[m], mclr[m], men[m]};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL model_dut%0d t=%0t: got %b want %b (state,disp,lap,clr,en)", m, $time, got, want);
        end
    endtask

    task automatic cycle(input logic r, input logic t, input logic [2:0] k);
        reset_n = r; tick = t; key_n = k;
        @(posedge clk);
        model_edge(r, t, k);
        @(negedge clk);
        cmp_model(0, {state0, disp_lap0, lap_load0, cnt_clr0, cnt_en0});
        cmp_model(1, {state1, disp_lap1, lap_load1, cnt_clr1, cnt_en1});
        obs_en   += int'(cnt_en0);
        obs_clr  += int'(cnt_clr0);
        obs_lap  += int'(lap_load0);
        obs_lap1 += int'(lap_load1);
    endtask

    task automatic run_seg(input logic [2:0] k, input int n);
        obs_en = 0; obs_clr = 0; obs_lap = 0; obs_lap1 = 0;
        repeat (3) cycle(1'b1, 1'b0, k);
        repeat (n) begin
            cycle(1'b1, 1'b1, k);
            repeat (3) cycle(1'b1, 1'b0, k);
        end
    endtask

    task automatic press_coincident(input logic [2:0] k);
        repeat (3) cycle(1'b1, 1'b0, k);
        cycle(1'b1, 1'b1, k);
        repeat (3) cycle(1'b1, 1'b0, k);
        cycle(1'b1, 1'b1, k);
        cycle(1'b1, 1'b1, k);
    endtask

    initial begin
        logic [2:0] key_r;
        for (int s = 0; s < 4; s++)
            for (int e = 0; e < 4; e++) begin
                nxt_tbl[s][e] = s;
                act_tbl[s][e] = 0;
            end
        nxt_tbl[0][1] = 1; act_tbl[0][2] = 1;
        nxt_tbl[1][1] = 3; nxt_tbl[1][3] = 2; act_tbl[1][3] = 2 | 4;
        nxt_tbl[2][1] = 3; act_tbl[2][1] = 8;
        nxt_tbl[2][2] = 1; act_tbl[2][2] = 8; act_tbl[2][3] = 2;
        nxt_tbl[3][1] = 1; nxt_tbl[3][2] = 0; act_tbl[3][2] = 1;

        segs = '{
            '{3'b111, 20, 2'b00,  0, 0, 0, 1'b0},
            '{3'b110,  3, 2'b01,  1, 0, 0, 1'b0},
            '{3'b111, 10, 2'b01, 10, 0, 0, 1'b0},
            '{3'b110,  3, 2'b11,  2, 0, 0, 1'b0},
            '{3'b111,  3, 2'b11,  0, 0, 0, 1'b0},
            '{3'b011,  3, 2'b00,  0, 1, 0, 1'b0},
            '{3'b111,  3, 2'b00,  0, 0, 0, 1'b0},
            '{3'b011,  3, 2'b00,  0, 1, 0, 1'b0},
            '{3'b111,  3, 2'b00,  0, 0, 0, 1'b0},
            '{3'b110,  3, 2'b01,  1, 0, 0, 1'b0},
            '{3'b111,  3, 2'b01,  3, 0, 0, 1'b0},
            '{3'b011,  3, 2'b01,  3, 0, 0, 1'b0},
            '{3'b111,  3, 2'b01,  3, 0, 0, 1'b0},
            '{3'b101,  3, 2'b10,  3, 0, 1, 1'b1},
            '{3'b111,  3, 2'b10,  3, 0, 0, 1'b1},
            '{3'b101,  3, 2'b10,  3, 0, 1, 1'b1},
            '{3'b111,  3, 2'b10,  3, 0, 0, 1'b1},
            '{3'b011,  3, 2'b01,  3, 0, 0, 1'b0},
            '{3'b111,  3, 2'b01,  3, 0, 0, 1'b0},
            '{3'b101,  3, 2'b10,  3, 0, 1, 1'b1},
            '{3'b111,  3, 2'b10,  3, 0, 0, 1'b1},
            '{3'b110,  3, 2'b11,  2, 0, 0, 1'b0},
            '{3'b111,  3, 2'b11,  0, 0, 0, 1'b0},
            '{3'b110,  3, 2'b01,  1, 0, 0, 1'b0},
            '{3'b111,  3, 2'b01,  3, 0, 0, 1'b0},
            '{3'b010,  3, 2'b11,  2, 0, 0, 1'b0},
            '{3'b111,  3, 2'b11,  0, 0, 0, 1'b0},
            '{3'b110,  3, 2'b01,  1, 0, 0, 1'b0},
            '{3'b111,  3, 2'b01,  3, 0, 0, 1'b0}
        };

        reset_n = 1'b0; tick = 1'b0; key_n = 3'b111;
        repeat (3) cycle(1'b0, 1'b0, 3'b111);
        chk("reset_state", int'(state0), 0);

        for (int i = 0; i < 29; i++) begin
            run_seg(segs[i].key, segs[i].nt);
            chk($sformatf("seg%0d_state", i), int'(state0), int'(segs[i].st));
            chk($sformatf("seg%0d_en", i), obs_en, segs[i].en);
            chk($sformatf("seg%0d_clr", i), obs_clr, segs[i].clr);
            chk($sformatf("seg%0d_lap", i), obs_lap, segs[i].lap);
            chk($sformatf("seg%0d_disp", i), int'(disp_lap0), int'(segs[i].disp));
        end

        obs_en = 0; obs_clr = 0; obs_lap = 0; obs_lap1 = 0;
        for (int i = 0; i < 6; i++) begin
            logic [2:0] kb;
            kb = (i % 2 == 0) ? 3'b101 : 3'b111;
            repeat (3) cycle(1'b1, 1'b0, kb);
            cycle(1'b1, 1'b1, kb);
        end
        repeat (3) cycle(1'b1, 1'b0, 3'b111);
        chk("bounce_lap_db2", obs_lap, 0);
        chk("bounce_state_db2", int'(state0), 1);
        chk("bounce_en_db2", obs_en, 6);
        chk("bounce_lap_db1", obs_lap1, 3);
        chk("bounce_state_db1", int'(state1), 2);

        run_seg(3'b011, 3);
        run_seg(3'b111, 1);
        cycle(1'b1, 1'b1, 3'b111);
        chk("pre_reset_en", int'(cnt_en0), 1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outs", int'({state0, disp_lap0, lap_load0, cnt_clr0, cnt_en0}), 0);
        repeat (3) cycle(1'b0, 1'b1, 3'b111);
        run_seg(3'b111, 20);
        chk("post_reset_en", obs_en, 0);
        chk("post_reset_state", int'(state0), 0);

        repeat (2) cycle(1'b0, 1'b0, 3'b110);
        run_seg(3'b110, 5);
        chk("held_key_state", int'(state0), 0);
        chk("held_key_en", obs_en, 0);
        run_seg(3'b111, 3);
        run_seg(3'b110, 3);
        chk("repress_state", int'(state0), 1);

        run_seg(3'b111, 3);
        press_coincident(3'b110);
        chk("start_run_tick_en", int'(cnt_en0), 1);
        chk("start_run_tick_state", int'(state0), 3);
        run_seg(3'b111, 3);
        run_seg(3'b011, 3);
        run_seg(3'b111, 3);
        chk("idle_before_start", int'(state0), 0);
        press_coincident(3'b110);
        chk("start_idle_tick_en", int'(cnt_en0), 0);
        chk("start_idle_tick_state", int'(state0), 1);
        repeat (3) cycle(1'b1, 1'b0, 3'b110);
        cycle(1'b1, 1'b1, 3'b110);
        chk("start_idle_next_tick_en", int'(cnt_en0), 1);

        key_r = 3'b111;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 7) == 0) key_r[b] = ~key_r[b];
            cycle(($urandom_range(0, 999) != 0), ($urandom_range(0, 2) == 0), key_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
